// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/ack data-memory port, aligns load lanes, and owns the MEM/WB register.
// Optional misaligned-access trap: define MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [4:0]        WriteReg,
    input  logic [2:0]        Memfunc,
    input  logic [31:0]       ALUData,
    input  logic [31:0]       RtData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              Stall,
    output logic              AddrErr,
    output logic              wb_MemtoReg,
    output logic              wb_RegWrite,
    output logic [4:0]        wb_WriteReg,
    output logic [2:0]        wb_Memfunc,
    output logic [31:0]       wb_ALUData,
    output logic [31:0]       wb_RtData,
    output logic [31:0]       wb_MemData
);
    localparam logic [2:0] F_BS = 3'd0, F_BU = 3'd1, F_HS = 3'd2, F_HU = 3'd3,
                           F_WD = 3'd4, F_WL = 3'd5, F_WR = 3'd6;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, state_nxt;

    logic [1:0]  off;
    logic        access, misalign, issue;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, load_data;

    assign off    = ALUData[1:0];
    assign access = Valid & (MemRead | MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = access & ((((Memfunc == F_HS) || (Memfunc == F_HU)) && off[0]) ||
                                ((Memfunc == F_WD) && (off != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign issue = access & ~misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (issue && !mem_ack) state_nxt = S_WAIT;
            S_WAIT: if (mem_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request is gated by reset so an in-flight access drops the moment rst rises.
    always_comb begin
        mem_req = 1'b0;
        if (!rst) mem_req = (state == S_WAIT) | issue;
        Stall   = mem_req & ~mem_ack;
        mem_we  = mem_req & MemWrite;
        mem_be  = mem_req ? lane_be : 4'b0000;
    end

    assign mem_addr  = {ALUData[ADDR_W-1:2], 2'b00};
    assign mem_wdata = lane_wdata;

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = RtData;
        if (MemWrite) begin
            case (Memfunc)
                F_BS, F_BU: begin
                    lane_be    = 4'b0001 << off;
                    lane_wdata = {4{RtData[7:0]}};
                end
                F_HS, F_HU: begin
                    lane_be    = off[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{RtData[15:0]}};
                end
                F_WL:    lane_be = 4'b1100;
                F_WR:    lane_be = 4'b0011;
                default: lane_be = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (Memfunc)
            F_BS, F_BU: load_data = mem_rdata >> (8 * off);
            F_HS, F_HU: load_data = mem_rdata >> (16 * off[1]);
            default:    load_data = mem_rdata;
        endcase
    end

    // A stalled cycle loads a bubble so WB never repeats a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_MemtoReg <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_WriteReg <= '0;
            wb_Memfunc  <= '0;
            wb_ALUData  <= '0;
            wb_RtData   <= '0;
            wb_MemData  <= '0;
        end else begin
            wb_MemtoReg <= Valid & ~Stall & MemtoReg;
            wb_RegWrite <= Valid & ~Stall & ~misalign & RegWrite;
            wb_WriteReg <= WriteReg;
            wb_Memfunc  <= Memfunc;
            wb_ALUData  <= ALUData;
            wb_RtData   <= RtData;
            wb_MemData  <= MemRead ? load_data : 32'h0;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) AddrErr <= 1'b0;
        else     AddrErr <= misalign & (state == S_IDLE);
    end
`else
    assign AddrErr = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: zero-wait, multi-wait, non-access, reset-in-WAIT, alignment, back-to-back.
module tb_mem_stage;
    localparam logic [2:0] F_BS = 3'd0, F_BU = 3'd1, F_HS = 3'd2, F_HU = 3'd3,
                           F_WD = 3'd4, F_WL = 3'd5, F_WR = 3'd6;

    logic        clk, rst;
    logic        Valid, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [4:0]  WriteReg;
    logic [2:0]  Memfunc;
    logic [31:0] ALUData, RtData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack, Stall, AddrErr;
    logic        wb_MemtoReg, wb_RegWrite;
    logic [4:0]  wb_WriteReg;
    logic [2:0]  wb_Memfunc;
    logic [31:0] wb_ALUData, wb_RtData, wb_MemData;

    int checks = 0;
    int failures = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .WriteReg(WriteReg), .Memfunc(Memfunc),
        .ALUData(ALUData), .RtData(RtData), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .Stall(Stall), .AddrErr(AddrErr), .wb_MemtoReg(wb_MemtoReg),
        .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg), .wb_Memfunc(wb_Memfunc),
        .wb_ALUData(wb_ALUData), .wb_RtData(wb_RtData), .wb_MemData(wb_MemData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic [4:0] wr_reg, input logic [2:0] fn,
                         input logic [31:0] alu, input logic [31:0] rt);
        Valid = v; MemRead = rd; MemWrite = wr; MemtoReg = m2r; RegWrite = rw;
        WriteReg = wr_reg; Memfunc = fn; ALUData = alu; RtData = rt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, F_BS, 32'h0, 32'h0);
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    // Inputs change on the negedge; combinational outputs are sampled #1 later, registers #1 after posedge.
    task automatic to_edge();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #12;
        chk("rst_wb_regwrite", {31'b0, wb_RegWrite}, 32'h0);
        chk("rst_wb_aludata",  wb_ALUData, 32'h0);
        chk("rst_mem_req",     {31'b0, mem_req}, 32'h0);
        chk("rst_stall",       {31'b0, Stall}, 32'h0);
        chk("rst_addrerr",     {31'b0, AddrErr}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Zero-wait byte load at offset 3
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, F_BS, 32'h0000_1003, 32'h0);
        mem_rdata = 32'h80AA_BBCC; mem_ack = 1'b1;
        #1;
        chk("bs_req",   {31'b0, mem_req}, 32'h1);
        chk("bs_stall", {31'b0, Stall}, 32'h0);
        chk("bs_addr",  mem_addr, 32'h0000_1000);
        chk("bs_be",    {28'b0, mem_be}, 32'hF);
        chk("bs_we",    {31'b0, mem_we}, 32'h0);
        to_edge();
        chk("bs_memdata", {24'b0, wb_MemData[7:0]}, 32'h80);
        chk("bs_func",    {29'b0, wb_Memfunc}, {29'b0, F_BS});
        chk("bs_rw",      {31'b0, wb_RegWrite}, 32'h1);
        chk("bs_wreg",    {27'b0, wb_WriteReg}, 32'd5);

        // Halfword store at 0x2002, ack on the fourth cycle
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, F_HU, 32'h0000_2002, 32'h0000_BEEF);
            mem_ack = (c == 3);
            #1;
            chk($sformatf("hu_req%0d", c),   {31'b0, mem_req}, 32'h1);
            chk($sformatf("hu_we%0d", c),    {31'b0, mem_we}, 32'h1);
            chk($sformatf("hu_be%0d", c),    {28'b0, mem_be}, 32'hC);
            chk($sformatf("hu_wd%0d", c),    mem_wdata, 32'hBEEF_BEEF);
            chk($sformatf("hu_stall%0d", c), {31'b0, Stall}, (c == 3) ? 32'h0 : 32'h1);
            to_edge();
            chk($sformatf("hu_bubble%0d", c), {31'b0, wb_RegWrite}, 32'h0);
        end
        chk("hu_rtdata", wb_RtData, 32'h0000_BEEF);

        // Byte store at offset 1, WL and WR word-part stores, zero-wait
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, F_BU, 32'h0000_4001, 32'h1234_56A5);
        mem_ack = 1'b1;
        #1;
        chk("sb_be", {28'b0, mem_be}, 32'h2);
        chk("sb_wd", mem_wdata, 32'hA5A5_A5A5);
        @(negedge clk);
        Memfunc = F_WL; #1;
        chk("wl_be", {28'b0, mem_be}, 32'hC);
        chk("wl_wd", mem_wdata, 32'h1234_56A5);
        @(negedge clk);
        Memfunc = F_WR; #1;
        chk("wr_be", {28'b0, mem_be}, 32'h3);

        // Halfword signed load at offset 2
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, F_HS, 32'h0000_5002, 32'h0);
        mem_rdata = 32'hDEAD_0000; mem_ack = 1'b1;
        to_edge();
        chk("hs_memdata", {16'b0, wb_MemData[15:0]}, 32'h0000_DEAD);

        // Non-access ALU op
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, F_BS, 32'h1234_5678, 32'h0);
        mem_ack = 1'b0;
        #1;
        chk("alu_req",   {31'b0, mem_req}, 32'h0);
        chk("alu_stall", {31'b0, Stall}, 32'h0);
        to_edge();
        chk("alu_data", wb_ALUData, 32'h1234_5678);
        chk("alu_rw",   {31'b0, wb_RegWrite}, 32'h1);

        // Invalid entry becomes a bubble
        @(negedge clk);
        Valid = 1'b0;
        to_edge();
        chk("inv_rw", {31'b0, wb_RegWrite}, 32'h0);

        // Reset while waiting on memory
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, F_WD, 32'h0000_6000, 32'h0);
        mem_ack = 1'b0;
        to_edge();
        chk("rw_stall_pre", {31'b0, Stall}, 32'h1);
        @(negedge clk);
        rst = 1'b1; #1;
        chk("rw_req",   {31'b0, mem_req}, 32'h0);
        chk("rw_stall", {31'b0, Stall}, 32'h0);
        chk("rw_alu",   wb_ALUData, 32'h0);
        @(negedge clk);
        rst = 1'b0; idle(); mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
        chk("rw_late_req", {31'b0, mem_req}, 32'h0);
        to_edge();
        chk("rw_late_rw",  {31'b0, wb_RegWrite}, 32'h0);
        chk("rw_late_md",  wb_MemData, 32'h0);

        // Misaligned word load at 0x0002
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, F_WD, 32'h0000_0002, 32'h0);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        chk("al_req", {31'b0, mem_req}, 32'h0);
        to_edge();
        chk("al_err", {31'b0, AddrErr}, 32'h1);
        chk("al_rw",  {31'b0, wb_RegWrite}, 32'h0);
        @(negedge clk);
        idle();
        to_edge();
        chk("al_err_pulse", {31'b0, AddrErr}, 32'h0);
`else
        chk("al_req",  {31'b0, mem_req}, 32'h1);
        chk("al_addr", mem_addr, 32'h0);
        mem_ack = 1'b1;
        to_edge();
        chk("al_err", {31'b0, AddrErr}, 32'h0);
        chk("al_rw",  {31'b0, wb_RegWrite}, 32'h1);
`endif

        // Back-to-back word loads, one wait cycle each
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'(k + 1), F_WD, 32'h0000_3000 + 32'(4 * k), 32'h0);
            mem_ack = 1'b0;
            #1;
            chk($sformatf("bb_req%0d", k),   {31'b0, mem_req}, 32'h1);
            chk($sformatf("bb_stall%0d", k), {31'b0, Stall}, 32'h1);
            to_edge();
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
            to_edge();
            chk($sformatf("bb_md%0d", k),   wb_MemData, (k == 0) ? 32'h1111_1111 : 32'h2222_2222);
            chk($sformatf("bb_wreg%0d", k), {27'b0, wb_WriteReg}, 32'(k + 1));
            chk($sformatf("bb_rw%0d", k),   {31'b0, wb_RegWrite}, 32'h1);
        end

        @(negedge clk);
        idle();
        to_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
